// File: rtl/mem_stage.sv
// Memory stage: issues data-memory requests for loads/stores, extracts and
// extends load data, stalls the front of the pipe while an access is open,
// and registers the MEM/WB result.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [1:0]  i_rd_dest_select,
  input  logic [2:0]  i_store_sel,
  input  logic [2:0]  i_load_sel,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_immediate,
  input  logic [31:0] i_pc_plus_4,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_rd_wen,
  output logic        o_wb_trap,
  output logic [4:0]  o_wb_rd_waddr,
  output logic [31:0] o_wb_data
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = 4;
  localparam int unsigned RADRW = 5;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  state_e state_q;

  logic [1:0]       off;
  logic             is_store;
  logic             is_mem;
  size_e            size;
  logic             load_unsigned;
  logic             misaligned;
  logic             trap_c;
  logic             memop_c;
  logic [MASKW-1:0] mask_c;
  logic [XLEN-1:0]  wdata_c;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  load_data_c;
  logic             req_c;
  logic             stall_c;

  logic             wb_valid_q,    wb_valid_d;
  logic             wb_rd_wen_q,   wb_rd_wen_d;
  logic             wb_trap_q,     wb_trap_d;
  logic [RADRW-1:0] wb_rd_waddr_q, wb_rd_waddr_d;
  logic [XLEN-1:0]  wb_data_q,     wb_data_d;

  // Access decode: size, alignment, byte mask, lane-replicated store data.
  always_comb begin
    off           = i_alu_result[1:0];
    is_store      = i_dmem_wen;
    is_mem        = i_dmem_ren | i_dmem_wen;
    size          = SZ_W;
    load_unsigned = 1'b0;
    if (is_store) begin
      case (i_store_sel)
        3'b000:  size = SZ_B;
        3'b001:  size = SZ_H;
        default: size = SZ_W;
      endcase
    end else begin
      case (i_load_sel)
        3'b000:  size = SZ_B;
        3'b001:  size = SZ_H;
        3'b100: begin size = SZ_B; load_unsigned = 1'b1; end
        3'b101: begin size = SZ_H; load_unsigned = 1'b1; end
        default: size = SZ_W;
      endcase
    end
    misaligned = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    trap_c     = i_valid & is_mem & misaligned;
    memop_c    = i_valid & is_mem & ~misaligned;
    case (size)
      SZ_B: begin
        mask_c  = MASKW'(4'b0001 << off);
        wdata_c = {4{i_rs2_data[7:0]}};
      end
      SZ_H: begin
        mask_c  = off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_rs2_data[15:0]}};
      end
      default: begin
        mask_c  = 4'b1111;
        wdata_c = i_rs2_data;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte = i_dmem_rdata[{off, 3'b000} +: 8];
    ld_half = off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (size)
      SZ_B:    load_data_c = load_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_data_c = load_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data_c = i_dmem_rdata;
    endcase
  end

  // Request drive and pipeline stall.
  always_comb begin
    req_c   = (state_q == S_IDLE) & memop_c;
    stall_c = ((state_q == S_IDLE) & memop_c & ~(is_store & i_dmem_ready)) |
              ((state_q == S_RESP) & ~i_dmem_rvalid);
    o_stall      = stall_c;
    o_dmem_req   = req_c;
    o_dmem_wen   = req_c & is_store;
    o_dmem_addr  = req_c ? {i_alu_result[31:2], 2'b00} : '0;
    o_dmem_mask  = req_c ? mask_c : '0;
    o_dmem_wdata = req_c ? wdata_c : '0;
  end

  // Access FSM: IDLE issues the request, RESP waits for load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (memop_c && !is_store && i_dmem_ready) state_q <= S_RESP;
        S_RESP:  if (i_dmem_rvalid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Writeback next-state: retire current instruction or insert a bubble.
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_rd_wen_d   = 1'b0;
    wb_trap_d     = 1'b0;
    wb_rd_waddr_d = wb_rd_waddr_q;
    wb_data_d     = wb_data_q;
    if (!stall_c) begin
      wb_valid_d    = i_valid;
      wb_trap_d     = trap_c;
      wb_rd_wen_d   = i_valid & i_rd_wen & ~trap_c & ~(is_store & is_mem);
      wb_rd_waddr_d = i_rd_waddr;
      case (i_rd_dest_select)
        2'b00:   wb_data_d = i_alu_result;
        2'b01:   wb_data_d = load_data_c;
        2'b10:   wb_data_d = i_pc_plus_4;
        default: wb_data_d = i_immediate;
      endcase
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_rd_wen_q   <= 1'b0;
      wb_trap_q     <= 1'b0;
      wb_rd_waddr_q <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_rd_wen_q   <= wb_rd_wen_d;
      wb_trap_q     <= wb_trap_d;
      wb_rd_waddr_q <= wb_rd_waddr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign o_wb_valid    = wb_valid_q;
  assign o_wb_rd_wen   = wb_rd_wen_q;
  assign o_wb_trap     = wb_trap_q;
  assign o_wb_rd_waddr = wb_rd_waddr_q;
  assign o_wb_data     = wb_data_q;

endmodule
